// File: rtl/dpram_rd_arb_pkg.sv
// Shared types and constants for the round-robin DPRAM read arbiter.
// Holds the default requester count, index width helper and the response tag.
package dpram_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int N_REQ_MAX = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tags are sized for the largest legal requester count so one type serves every build.
  localparam int IDX_W = idx_width(N_REQ_MAX);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/dpram_rd_arb_if.sv
// Request/pointer/grant bundle between the arbiter top and its rr_arb grant logic.
interface dpram_rd_arb_if
  import dpram_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF
);

  logic [N-1:0]     req;
  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     gnt;

  modport master (output req, output ptr, input gnt);
  modport slave  (input req, input ptr, output gnt);

endinterface

// File: rtl/dpram_rd_arb_rr_arb.sv
// Round-robin grant: first asserted request found searching upward from ptr, wrapping.
module rr_arb
  import dpram_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF
) (
  dpram_rd_arb_if.slave arb
);

  localparam int IW = idx_width(N);

  logic found;
  int   j;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    arb.gnt = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(arb.ptr) + i;
      if (j >= N) j = j - N;
      if (!found && arb.req[IW'(j)]) begin
        arb.gnt[IW'(j)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_rd_arb.sv
// Round-robin arbiter sharing one DPRAM read port among N_REQ requesters, with tag routing.
// Optional stall statistics counter enabled by defining DPRAM_RD_ARB_STAT_EN.
module dpram_rd_arb
  import dpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_DELAY  = 1,
  parameter int N_REQ      = N_REQ_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic                        o_en_b,
  output logic [ADDR_WIDTH-1:0]       o_addr_b,
  input  logic [DATA_WIDTH-1:0]       i_data_b,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]       o_rsp_data
`ifdef DPRAM_RD_ARB_STAT_EN
  ,
  output logic [15:0]                 o_stall_cnt
`endif
);

  logic [IDX_W-1:0]      ptr;
  logic [N_REQ-1:0]      gnt;
  logic                  grant_any;
  logic [IDX_W-1:0]      gnt_idx;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  tag_t                  pipe [OUT_DELAY];
  tag_t                  tail;
  logic [N_REQ-1:0]      rsp_valid;

  dpram_rd_arb_if #(.N(N_REQ)) arb_bus ();

  // Masking requests during reset keeps grant, enable and address at zero.
  assign arb_bus.req = i_rst ? '0 : i_req_valid;
  assign arb_bus.ptr = ptr;
  assign gnt         = arb_bus.gnt;

  rr_arb #(.N(N_REQ)) u_rr_arb (.arb(arb_bus));

  assign grant_any   = |gnt;
  assign o_req_ready = gnt;
  assign o_en_b      = grant_any;
  assign o_addr_b    = gnt_addr;

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        gnt_idx  = IDX_W'(k);
        gnt_addr = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Clearing the tag stages on reset is what drops reads still in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
      for (int s = 0; s < OUT_DELAY; s++) pipe[s] <= '0;
    end else begin
      if (grant_any) ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      pipe[0] <= '{valid: grant_any, idx: gnt_idx};
      for (int s = 1; s < OUT_DELAY; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign tail = pipe[OUT_DELAY-1];

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (tail.valid && tail.idx == IDX_W'(k)) rsp_valid[k] = 1'b1;
    end
  end

  assign o_rsp_valid = rsp_valid;
  assign o_rsp_data  = tail.valid ? i_data_b : '0;

`ifdef DPRAM_RD_ARB_STAT_EN
  logic        stall;
  logic [15:0] stall_cnt;

  // A stall is any cycle where a valid requester is left waiting.
  assign stall = |(arb_bus.req & ~gnt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                             stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_dpram_rd_arb.sv
// Bench for dpram_rd_arb: two instances (read latency 1 and 3) share stimulus and are
// compared every cycle against a queue-based arbitration/response model.
module tb_dpram_rd_arb;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DA = 1;
  localparam int DB = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;

  logic [N-1:0]  ready_a, ready_b, rsp_valid_a, rsp_valid_b;
  logic          en_a, en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b, rsp_data_a, rsp_data_b;
`ifdef DPRAM_RD_ARB_STAT_EN
  logic [15:0]   stall_a, stall_b;
`endif

  always #5 clk = ~clk;

  dpram_rd_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_DELAY(DA), .N_REQ(N)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_req_ready(ready_a), .o_en_b(en_a), .o_addr_b(addr_a), .i_data_b(data_a),
    .o_rsp_valid(rsp_valid_a), .o_rsp_data(rsp_data_a)
`ifdef DPRAM_RD_ARB_STAT_EN
    , .o_stall_cnt(stall_a)
`endif
  );

  dpram_rd_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_DELAY(DB), .N_REQ(N)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_req_ready(ready_b), .o_en_b(en_b), .o_addr_b(addr_b), .i_data_b(data_b),
    .o_rsp_valid(rsp_valid_b), .o_rsp_data(rsp_data_b)
`ifdef DPRAM_RD_ARB_STAT_EN
    , .o_stall_cnt(stall_b)
`endif
  );

  // RAM contents are a fixed hash of the address; unread cycles return noise.
  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [DW-1:0] ram_pipe_b [DB];

  always_ff @(posedge clk) begin
    data_a        <= en_a ? ram_word(addr_a) : $urandom;
    ram_pipe_b[0] <= en_b ? ram_word(addr_b) : $urandom;
    for (int s = 1; s < DB; s++) ram_pipe_b[s] <= ram_pipe_b[s-1];
  end
  assign data_b = ram_pipe_b[DB-1];

  // Reference model: pointer as an integer plus a history of per-cycle grants.
  typedef struct {
    bit            v;
    int            idx;
    logic [AW-1:0] addr;
  } grant_t;

  grant_t hist[$];
  int     m_ptr;
  int     n_tests;
  int     n_fail;

  function automatic logic [AW-1:0] addr_of(input int k);
    return req_addr[k*AW +: AW];
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic void model_rsp(input int d, output logic [N-1:0] v, output logic [DW-1:0] dat);
    v   = '0;
    dat = '0;
    if (!rst && hist.size() >= d && hist[hist.size()-d].v) begin
      v   = N'(1) << hist[hist.size()-d].idx;
      dat = ram_word(hist[hist.size()-d].addr);
    end
  endfunction

  // One clock cycle: compare both instances with the model, then advance the model.
  task automatic tick();
    int            g;
    logic [N-1:0]  e_ready, e_rv_a, e_rv_b;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd_a, e_rd_b;
    #1;
    g       = rst ? -1 : model_grant();
    e_ready = (g >= 0) ? (N'(1) << g) : '0;
    e_en    = (g >= 0);
    e_addr  = (g >= 0) ? addr_of(g) : '0;
    model_rsp(DA, e_rv_a, e_rd_a);
    model_rsp(DB, e_rv_b, e_rd_b);
    n_tests += 4;
    if ({ready_a, en_a, addr_a} !== {e_ready, e_en, e_addr}) begin
      n_fail++;
      $display("FAIL grant_a t=%0t: ready=%b en=%b addr=%h, expected ready=%b en=%b addr=%h",
               $time, ready_a, en_a, addr_a, e_ready, e_en, e_addr);
    end
    if ({ready_b, en_b, addr_b} !== {e_ready, e_en, e_addr}) begin
      n_fail++;
      $display("FAIL grant_b t=%0t: ready=%b en=%b addr=%h, expected ready=%b en=%b addr=%h",
               $time, ready_b, en_b, addr_b, e_ready, e_en, e_addr);
    end
    if ({rsp_valid_a, rsp_data_a} !== {e_rv_a, e_rd_a}) begin
      n_fail++;
      $display("FAIL rsp_a t=%0t: valid=%b data=%h, expected valid=%b data=%h",
               $time, rsp_valid_a, rsp_data_a, e_rv_a, e_rd_a);
    end
    if ({rsp_valid_b, rsp_data_b} !== {e_rv_b, e_rd_b}) begin
      n_fail++;
      $display("FAIL rsp_b t=%0t: valid=%b data=%h, expected valid=%b data=%h",
               $time, rsp_valid_b, rsp_data_b, e_rv_b, e_rd_b);
    end
    @(posedge clk);
    if (rst) begin
      m_ptr = 0;
      hist.delete();
    end else begin
      if (g >= 0) begin
        hist.push_back('{v: 1'b1, idx: g, addr: addr_of(g)});
        m_ptr = (g + 1) % N;
      end else begin
        hist.push_back('{v: 1'b0, idx: 0, addr: '0});
      end
      if (hist.size() > 8) hist.delete(0);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (DB + 1) tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_addr  = 40'({$urandom, $urandom});
    #1;
    n_tests += 2;
    if ({ready_a, en_a, addr_a, rsp_valid_a, rsp_data_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: ready=%b en=%b addr=%h rsp=%b data=%h, expected all zero",
               ready_a, en_a, addr_a, rsp_valid_a, rsp_data_a);
    end
    if ({ready_b, en_b, addr_b, rsp_valid_b, rsp_data_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: ready=%b en=%b addr=%h rsp=%b data=%h, expected all zero",
               ready_b, en_b, addr_b, rsp_valid_b, rsp_data_b);
    end
    tick();
    tick();
    rst = 1'b0;
    drain();
  endtask

  task automatic test_rotate();
    logic [N-1:0] exp_g;
    apply_reset();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      req_addr = 40'({$urandom, $urandom});
      exp_g    = N'(1) << (c % N);
      #1;
      n_tests++;
      if (ready_a !== exp_g) begin
        n_fail++;
        $display("FAIL rotate cycle %0d: ready=%b, expected %b", c, ready_a, exp_g);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_single();
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 3) ? 4'b0100 : 4'b0000;
      req_addr  = 40'({$urandom, $urandom});
      req_addr[2*AW +: AW] = AW'(16 + c);
      exp_rv = (c >= 3 && c <= 5) ? 4'b0100 : 4'b0000;
      exp_rd = (c >= 3 && c <= 5) ? ram_word(AW'(16 + c - 3)) : '0;
      #1;
      n_tests += 2;
      if (en_b !== (c < 3)) begin
        n_fail++;
        $display("FAIL single_en cycle %0d: en=%b, expected %b", c, en_b, (c < 3));
      end
      if ({rsp_valid_b, rsp_data_b} !== {exp_rv, exp_rd}) begin
        n_fail++;
        $display("FAIL single_rsp cycle %0d: valid=%b data=%h, expected valid=%b data=%h",
                 c, rsp_valid_b, rsp_data_b, exp_rv, exp_rd);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_w [3];
    exp_w = '{4'b0001, 4'b0100, 4'b0001};
    apply_reset();
    req_valid = '1;
    repeat (3) tick();
    req_valid = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      req_addr = 40'({$urandom, $urandom});
      #1;
      n_tests++;
      if (ready_a !== exp_w[c]) begin
        n_fail++;
        $display("FAIL wrap step %0d: ready=%b, expected %b", c, ready_a, exp_w[c]);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    req_valid = 4'b0010;
    req_addr  = 40'({$urandom, $urandom});
    tick();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++;
      if ({rsp_valid_a, rsp_valid_b} !== '0) begin
        n_fail++;
        $display("FAIL inflight_drop cycle %0d: rsp_a=%b rsp_b=%b, expected none",
                 c, rsp_valid_a, rsp_valid_b);
      end
      tick();
    end
    req_valid = 4'b1110;
    #1;
    n_tests++;
    if ({ready_a, ready_b} !== {4'b0010, 4'b0010}) begin
      n_fail++;
      $display("FAIL first_after_reset: ready_a=%b ready_b=%b, expected 0010", ready_a, ready_b);
    end
    tick();
    drain();
  endtask

`ifdef DPRAM_RD_ARB_STAT_EN
  task automatic test_stall();
    apply_reset();
    req_valid = 4'b0011;
    repeat (10) tick();
    #1;
    n_tests++;
    if ({stall_a, stall_b} !== {16'd10, 16'd10}) begin
      n_fail++;
      $display("FAIL stall_count: a=%0d b=%0d, expected 10", stall_a, stall_b);
    end
    repeat (65524) @(negedge clk);
    n_tests++;
    if (stall_a !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL stall_near_sat: a=%h, expected fffe", stall_a);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({stall_a, stall_b} !== {16'hFFFF, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL stall_saturate: a=%h b=%h, expected ffff", stall_a, stall_b);
    end
    apply_reset();
    drain();
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req_valid = N'($urandom);
      req_addr  = 40'({$urandom, $urandom});
      tick();
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    m_ptr     = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    @(negedge clk);
    test_reset();
    test_rotate();
    test_single();
    test_wrap();
    test_reset_inflight();
`ifdef DPRAM_RD_ARB_STAT_EN
    test_stall();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
